// File: rtl/soin_gshare_predictor_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// soin_gshare_predictor_if : fetch/execute <-> predictor signal bundle
// Revision: 1.0
// ============================================================================
interface soin_gshare_predictor_if #(
  parameter int IDX_W       = 10,
  parameter int GHR_W       = 10,
  parameter int RAS_DEPTH_L = 4,
  parameter int META_W      = RAS_DEPTH_L + GHR_W + 2 + IDX_W
);
  logic              soin_bpredictor_stall;
  logic [31:0]       fetch_bpredictor_PC;
  logic [31:0]       fetch_bpredictor_inst;
  logic              fetch_redirect;
  logic [31:0]       fetch_redirect_PC;
  logic [31:0]       bpredictor_fetch_p_target;
  logic              bpredictor_fetch_p_dir;
  logic [META_W-1:0] bpredictor_fetch_meta;
  logic              bpredictor_ready;
  logic              execute_bpredictor_update;
  logic              execute_bpredictor_dir;
  logic              execute_bpredictor_miss;
  logic [META_W-1:0] execute_bpredictor_meta;
  logic              execute_bpredictor_recover_ras;

  modport master (
    output soin_bpredictor_stall, fetch_bpredictor_PC, fetch_bpredictor_inst,
           fetch_redirect, fetch_redirect_PC, execute_bpredictor_update,
           execute_bpredictor_dir, execute_bpredictor_miss,
           execute_bpredictor_meta, execute_bpredictor_recover_ras,
    input  bpredictor_fetch_p_target, bpredictor_fetch_p_dir,
           bpredictor_fetch_meta, bpredictor_ready
  );

  modport slave (
    input  soin_bpredictor_stall, fetch_bpredictor_PC, fetch_bpredictor_inst,
           fetch_redirect, fetch_redirect_PC, execute_bpredictor_update,
           execute_bpredictor_dir, execute_bpredictor_miss,
           execute_bpredictor_meta, execute_bpredictor_recover_ras,
    output bpredictor_fetch_p_target, bpredictor_fetch_p_dir,
           bpredictor_fetch_meta, bpredictor_ready
  );
endinterface
`default_nettype wire

// File: rtl/soin_gshare_predictor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// soin_gshare_predictor : 2-bit counter direction predictor, speculative GHR,
// circular RAS. Macro SOIN_GSHARE_HASH_EN selects PC^GHR indexing (else bimodal).
// Revision: 1.0
// ============================================================================
module soin_gshare_predictor #(
  parameter int IDX_W       = 10,
  parameter int GHR_W       = 10,
  parameter int RAS_DEPTH_L = 4,
  parameter int META_W      = RAS_DEPTH_L + GHR_W + 2 + IDX_W
) (
  input  wire logic              clk,
  input  wire logic              reset,
  soin_gshare_predictor_if.slave bp
);
  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam int c_CTR_LSB = IDX_W;
  localparam int c_GHR_LSB = IDX_W + 2;
  localparam int c_PTR_LSB = META_W - RAS_DEPTH_L;
  localparam logic [IDX_W-1:0]       c_IDX_LAST = '1;
  localparam logic [IDX_W-1:0]       c_IDX_ONE  = IDX_W'(1);
  localparam logic [RAS_DEPTH_L-1:0] c_PTR_ONE  = RAS_DEPTH_L'(1);

  state_t                 r_state;
  logic                   r_ready;
  logic [IDX_W-1:0]       r_init_cnt;
  logic [1:0]             r_tbl [0:(1<<IDX_W)-1];
  logic [31:0]            r_ras [0:(1<<RAS_DEPTH_L)-1];
  logic [31:0]            r_pc;
  logic [1:0]             r_ctr;
  logic [IDX_W-1:0]       r_idx;
  logic [GHR_W-1:0]       r_ghr;
  logic [RAS_DEPTH_L-1:0] r_ptr;

  logic                   w_run, w_stall;
  logic [1:0]             w_sel, w_esel;
  logic                   w_uncond, w_call, w_ret, w_cond, w_p_dir;
  logic [31:0]            w_inst, w_pc4, w_ras_top, w_target;
  logic [IDX_W-1:0]       w_idx;
  logic [IDX_W-1:0]       w_upd_idx;
  logic [1:0]             w_upd_ctr, w_ctr_next;
  logic [GHR_W-1:0]       w_upd_ghr;
  logic [RAS_DEPTH_L-1:0] w_upd_ptr;
  logic                   w_upd_en, w_miss, w_recover, w_push;
  logic                   w_tbl_we;
  logic [IDX_W-1:0]       w_tbl_waddr;
  logic [1:0]             w_tbl_wdata;
  logic                   w_unused;

  assign w_run    = (r_state == ST_RUN);
  assign w_stall  = bp.soin_bpredictor_stall;
  assign w_inst   = bp.fetch_bpredictor_inst;
  assign w_sel    = w_inst[31:30];
  assign w_uncond = w_inst[29];
  assign w_call   = w_inst[27];
  assign w_ret    = (w_inst[5:0] == 6'h3A) && (w_inst[16:11] == 6'h05);
  assign w_cond   = (w_sel == 2'b10) && !w_uncond;
  assign w_p_dir  = w_run && (w_uncond || r_ctr[1]);
  assign w_esel   = w_sel & {2{w_p_dir}};
  assign w_pc4    = r_pc + 32'd4;
  assign w_ras_top = r_ras[r_ptr - c_PTR_ONE];

`ifdef SOIN_GSHARE_HASH_EN
  logic [IDX_W-1:0] w_ghr_ext;
  always_comb begin
    w_ghr_ext = '0;
    w_ghr_ext[GHR_W-1:0] = r_ghr;
  end
  assign w_idx = bp.fetch_bpredictor_PC[IDX_W+1:2] ^ w_ghr_ext;
`else
  assign w_idx = bp.fetch_bpredictor_PC[IDX_W+1:2];
`endif

  always_comb begin
    w_target = w_pc4;
    if (bp.fetch_redirect) begin
      w_target = bp.fetch_redirect_PC;
    end else begin
      case (w_esel)
        2'b00:   w_target = w_pc4;
        2'b01:   w_target = w_ras_top;
        2'b10:   w_target = w_pc4 + {{16{w_inst[15]}}, w_inst[15:0]};
        default: w_target = {r_pc[31:28], w_inst[25:0], 2'b00};
      endcase
    end
  end

  assign w_upd_idx = bp.execute_bpredictor_meta[IDX_W-1:0];
  assign w_upd_ctr = bp.execute_bpredictor_meta[c_CTR_LSB +: 2];
  assign w_upd_ghr = bp.execute_bpredictor_meta[c_GHR_LSB +: GHR_W];
  assign w_upd_ptr = bp.execute_bpredictor_meta[c_PTR_LSB +: RAS_DEPTH_L];
  assign w_upd_en  = w_run && bp.execute_bpredictor_update;
  assign w_miss    = w_upd_en && bp.execute_bpredictor_miss;
  assign w_recover = bp.execute_bpredictor_recover_ras;
  assign w_push    = !w_stall && w_call && !w_recover;

  always_comb begin
    w_ctr_next = w_upd_ctr;
    if (bp.execute_bpredictor_dir) begin
      if (w_upd_ctr != 2'b11) w_ctr_next = w_upd_ctr + 2'b01;
    end else begin
      if (w_upd_ctr != 2'b00) w_ctr_next = w_upd_ctr - 2'b01;
    end
  end

  // The init sweep owns the single write port until the table is ready.
  assign w_tbl_we    = !w_run || w_upd_en;
  assign w_tbl_waddr = w_run ? w_upd_idx : r_init_cnt;
  assign w_tbl_wdata = w_run ? w_ctr_next : 2'b01;

  always_ff @(posedge clk) begin
    if (w_tbl_we) r_tbl[w_tbl_waddr] <= w_tbl_wdata;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_ras[r_ptr] <= w_pc4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + c_IDX_ONE;
          if (r_init_cnt == c_IDX_LAST) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN:  r_ready <= 1'b1;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Execute-side recovery (GHR miss, RAS pointer) is applied even while fetch stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc  <= '0;
      r_ctr <= 2'b00;
      r_idx <= '0;
      r_ghr <= '0;
      r_ptr <= '0;
    end else begin
      if (!w_stall) begin
        r_pc  <= bp.fetch_bpredictor_PC;
        r_idx <= w_idx;
        r_ctr <= w_run ? r_tbl[w_idx] : 2'b01;
      end
      if (w_miss)
        r_ghr <= {w_upd_ghr[GHR_W-2:0], bp.execute_bpredictor_dir};
      else if (!w_stall && w_cond)
        r_ghr <= {r_ghr[GHR_W-2:0], r_ctr[1]};
      if (w_recover)
        r_ptr <= w_upd_ptr;
      else if (!w_stall && w_call)
        r_ptr <= r_ptr + c_PTR_ONE;
      else if (!w_stall && w_ret)
        r_ptr <= r_ptr - c_PTR_ONE;
    end
  end

  assign bp.bpredictor_fetch_p_target = w_target;
  assign bp.bpredictor_fetch_p_dir    = w_p_dir;
  assign bp.bpredictor_fetch_meta     = {r_ptr, r_ghr, r_ctr, r_idx};
  assign bp.bpredictor_ready          = r_ready;

  assign w_unused = ^{w_inst[28], w_inst[26], w_upd_ghr[GHR_W-1],
                      bp.fetch_bpredictor_PC[31:IDX_W+2], bp.fetch_bpredictor_PC[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_soin_gshare_predictor.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for soin_gshare_predictor (default build, bimodal indexing).
module tb_soin_gshare_predictor;
  localparam int IDX_W       = 10;
  localparam int GHR_W       = 10;
  localparam int RAS_DEPTH_L = 4;
  localparam int META_W      = RAS_DEPTH_L + GHR_W + 2 + IDX_W;
  localparam logic [31:0] INST_COND = 32'h8000_0010;
  localparam logic [31:0] INST_CALL = 32'hE800_0000;
  localparam logic [31:0] INST_RET  = 32'h6000_283A;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        redir;
    logic [31:0] rpc;
    logic        dir;
    logic [31:0] tgt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [9];
  vec_t q [$];

  soin_gshare_predictor_if #(.IDX_W(IDX_W), .GHR_W(GHR_W), .RAS_DEPTH_L(RAS_DEPTH_L),
                             .META_W(META_W)) bp();

  soin_gshare_predictor #(.IDX_W(IDX_W), .GHR_W(GHR_W), .RAS_DEPTH_L(RAS_DEPTH_L),
                          .META_W(META_W)) dut (.clk(clk), .reset(reset), .bp(bp));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_ptr();
    return 32'(bp.bpredictor_fetch_meta[25:22]);
  endfunction
  function automatic logic [31:0] m_ghr();
    return 32'(bp.bpredictor_fetch_meta[21:12]);
  endfunction
  function automatic logic [31:0] m_ctr();
    return 32'(bp.bpredictor_fetch_meta[11:10]);
  endfunction
  function automatic logic [31:0] m_idx();
    return 32'(bp.bpredictor_fetch_meta[9:0]);
  endfunction
  function automatic logic [31:0] o_dir();
    return 32'(bp.bpredictor_fetch_p_dir);
  endfunction
  function automatic logic [31:0] o_rdy();
    return 32'(bp.bpredictor_ready);
  endfunction

  task automatic upd(input logic d, input logic m, input logic [9:0] ghr,
                     input logic [1:0] c, input logic [9:0] idx);
    bp.execute_bpredictor_update = 1'b1;
    bp.execute_bpredictor_dir    = d;
    bp.execute_bpredictor_miss   = m;
    bp.execute_bpredictor_meta   = {4'h0, ghr, c, idx};
  endtask

  task automatic upd_off();
    bp.execute_bpredictor_update = 1'b0;
    bp.execute_bpredictor_miss   = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (bp.bpredictor_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk(nm, n, 1024);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    vecs[0] = '{32'h0000_0200, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 32'h0000_0204};
    vecs[1] = '{32'h0000_0300, INST_COND,     1'b0, 32'h0, 1'b0, 32'h0000_0304};
    vecs[2] = '{32'h0000_0400, 32'hA000_FFF0, 1'b0, 32'h0, 1'b1, 32'h0000_03F4};
    vecs[3] = '{32'h1234_5670, 32'hE012_3456, 1'b0, 32'h0, 1'b1, 32'h1048_D158};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 32'h0000_0000};
    vecs[5] = '{32'h0000_0500, 32'hE000_0040, 1'b1, 32'hDEAD_0000, 1'b1, 32'hDEAD_0000};
    vecs[6] = '{32'h0000_0600, 32'h4000_0000, 1'b0, 32'h0, 1'b0, 32'h0000_0604};
    vecs[7] = '{32'h8000_0000, 32'hC000_1234, 1'b0, 32'h0, 1'b0, 32'h8000_0004};
    vecs[8] = '{32'h7FFF_FFF0, 32'hA000_7FFC, 1'b0, 32'h0, 1'b1, 32'h8000_7FF0};

    reset = 1'b1;
    bp.soin_bpredictor_stall          = 1'b0;
    bp.fetch_bpredictor_PC            = '0;
    bp.fetch_bpredictor_inst          = '0;
    bp.fetch_redirect                 = 1'b0;
    bp.fetch_redirect_PC              = '0;
    bp.execute_bpredictor_update      = 1'b0;
    bp.execute_bpredictor_dir         = 1'b0;
    bp.execute_bpredictor_miss        = 1'b0;
    bp.execute_bpredictor_meta        = '0;
    bp.execute_bpredictor_recover_ras = 1'b0;
    repeat (3) tick();
    chk("rst_ready", o_rdy(), 0);
    chk("rst_dir", o_dir(), 0);
    chk("rst_target", bp.bpredictor_fetch_p_target, 32'h4);
    chk("rst_meta", 32'(bp.bpredictor_fetch_meta), 0);

    // Reset in the middle of the sweep must restart it from entry 0.
    reset = 1'b0;
    repeat (300) tick();
    chk("sweep_busy", o_rdy(), 0);
    reset = 1'b1;
    #1;
    chk("midsweep_meta", 32'(bp.bpredictor_fetch_meta), 0);
    tick();
    reset = 1'b0;
    wait_ready("init_len");

    // Table vectors: one lookup per cycle, expected results queued at PC issue.
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) begin
        e = q.pop_front();
        bp.fetch_bpredictor_inst = e.inst;
        bp.fetch_redirect        = e.redir;
        bp.fetch_redirect_PC     = e.rpc;
      end
      if (i < 9) begin
        q.push_back(vecs[i]);
        bp.fetch_bpredictor_PC = vecs[i].pc;
      end
      #1;
      if (i > 0) begin
        chk($sformatf("vec%0d_dir", i - 1), o_dir(), 32'(e.dir));
        chk($sformatf("vec%0d_target", i - 1), bp.bpredictor_fetch_p_target, e.tgt);
      end
      tick();
    end
    bp.fetch_bpredictor_inst = '0;
    bp.fetch_redirect        = 1'b0;

    // Learning at PC 0x100 (index 0x40), including read-during-write.
    bp.fetch_bpredictor_PC = 32'h100;
    tick();
    bp.fetch_bpredictor_inst = INST_COND;
    #1;
    chk("learn0_dir", o_dir(), 0);
    chk("learn0_target", bp.bpredictor_fetch_p_target, 32'h104);
    chk("learn0_ctr", m_ctr(), 1);
    chk("learn0_idx", m_idx(), 32'h40);
    upd(1'b1, 1'b0, 10'h0, 2'b01, 10'h040);
    tick();
    upd_off();
    chk("rdw_old_ctr", m_ctr(), 1);
    tick();
    chk("learn1_ctr", m_ctr(), 2);
    chk("learn1_dir", o_dir(), 1);
    chk("learn1_target", bp.bpredictor_fetch_p_target, 32'h114);
    upd(1'b1, 1'b0, 10'h0, 2'b10, 10'h040);
    tick();
    upd_off();
    tick();
    chk("learn2_ctr", m_ctr(), 3);
    upd(1'b1, 1'b0, 10'h0, 2'b11, 10'h040);
    tick();
    upd_off();
    tick();
    chk("sat_ctr", m_ctr(), 3);

    // Speculative GHR shifting, then miss recovery overriding a fetch shift.
    bp.fetch_bpredictor_inst = '0;
    upd(1'b0, 1'b1, 10'h000, 2'b00, 10'h3FE);
    tick();
    upd_off();
    bp.fetch_bpredictor_inst = INST_COND;
    #1;
    chk("ghr_clear", m_ghr(), 0);
    chk("ghr_taken_dir", o_dir(), 1);
    tick();
    chk("ghr_1", m_ghr(), 32'b001);
    tick();
    chk("ghr_3", m_ghr(), 32'b011);
    tick();
    chk("ghr_7", m_ghr(), 32'b111);
    upd(1'b0, 1'b1, 10'b0000000011, 2'b00, 10'h3FE);
    tick();
    upd_off();
    bp.fetch_bpredictor_inst = '0;
    #1;
    chk("ghr_recover", m_ghr(), 32'b110);

    // Call / return pair.
    bp.fetch_bpredictor_PC = 32'h2000;
    tick();
    bp.fetch_bpredictor_inst = INST_CALL;
    bp.fetch_bpredictor_PC   = 32'h3000;
    #1;
    chk("call_ptr", m_ptr(), 0);
    chk("call_target", bp.bpredictor_fetch_p_target, 32'h0);
    tick();
    bp.fetch_bpredictor_inst = INST_RET;
    bp.fetch_bpredictor_PC   = 32'h4000;
    #1;
    chk("ret_ptr", m_ptr(), 1);
    chk("ret_dir", o_dir(), 1);
    chk("ret_target", bp.bpredictor_fetch_p_target, 32'h2004);
    tick();
    bp.fetch_bpredictor_inst = '0;
    #1;
    chk("ret_ptr_back", m_ptr(), 0);

    // 17 calls into a 16-entry stack.
    bp.fetch_bpredictor_PC = 32'h5000;
    tick();
    for (int k = 0; k < 17; k++) begin
      bp.fetch_bpredictor_inst = INST_CALL;
      bp.fetch_bpredictor_PC   = 32'h5000 + 32'(16 * (k + 1));
      tick();
    end
    bp.fetch_bpredictor_inst = INST_RET;
    #1;
    chk("wrap_ptr", m_ptr(), 1);
    chk("wrap_top", bp.bpredictor_fetch_p_target, 32'h5104);
    tick();
    chk("wrap_top2", bp.bpredictor_fetch_p_target, 32'h50F4);
    tick();
    bp.fetch_bpredictor_inst = '0;
    #1;
    chk("wrap_ptr_under", m_ptr(), 15);

    // RAS recovery wins over a same-cycle call.
    bp.fetch_bpredictor_inst          = INST_CALL;
    bp.execute_bpredictor_recover_ras = 1'b1;
    bp.execute_bpredictor_meta        = {4'd3, 10'h0, 2'b00, 10'h0};
    tick();
    bp.execute_bpredictor_recover_ras = 1'b0;
    bp.fetch_bpredictor_inst          = '0;
    #1;
    chk("recover_ptr", m_ptr(), 3);

    // Stall holds PC, GHR and RAS pointer even with a cond+call instruction.
    bp.fetch_bpredictor_PC = 32'h700;
    tick();
    chk("prestall_target", bp.bpredictor_fetch_p_target, 32'h704);
    bp.soin_bpredictor_stall = 1'b1;
    bp.fetch_bpredictor_inst = 32'h8800_0000;
    bp.fetch_bpredictor_PC   = 32'h900;
    tick();
    chk("stall_target", bp.bpredictor_fetch_p_target, 32'h704);
    chk("stall_ghr", m_ghr(), 32'b110);
    chk("stall_ptr", m_ptr(), 3);
    bp.soin_bpredictor_stall = 1'b0;
    bp.fetch_bpredictor_inst = '0;
    tick();
    chk("unstall_target", bp.bpredictor_fetch_p_target, 32'h904);
    chk("unstall_ghr", m_ghr(), 32'b110);

    // Asynchronous reset between edges.
    #1;
    reset = 1'b1;
    #1;
    chk("async_ready", o_rdy(), 0);
    chk("async_meta", 32'(bp.bpredictor_fetch_meta), 0);
    chk("async_target", bp.bpredictor_fetch_p_target, 32'h4);
    tick();
    reset = 1'b0;
    wait_ready("reinit_len");
    bp.fetch_bpredictor_PC = 32'h100;
    tick();
    bp.fetch_bpredictor_inst = INST_COND;
    #1;
    chk("reinit_ctr", m_ctr(), 1);
    chk("reinit_dir", o_dir(), 0);
    chk("reinit_target", bp.bpredictor_fetch_p_target, 32'h104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
